// File: rtl/task_launcher_pkg.sv
// ----------------------------------------------------------------------------
// task_launcher_pkg
// Shared definitions for the task launcher and its per-attempt timer:
//   - state_e   : one-hot FSM state encoding (IDLE/LAUNCH/WAIT/DONE)
//   - ST_*      : response status codes returned on rsp_status
//   - STATUS_W  : width of the status field
// Optional feature macro used by importers: TASK_LAUNCHER_RETRY_EN.
// ----------------------------------------------------------------------------
package task_launcher_pkg;

    localparam int STATUS_W = 2;

    // One-hot state codes; any other value is treated as illegal.
    localparam logic [3:0] IDLE_CODE   = 4'h1;
    localparam logic [3:0] LAUNCH_CODE = 4'h2;
    localparam logic [3:0] WAIT_CODE   = 4'h4;
    localparam logic [3:0] DONE_CODE   = 4'h8;

    typedef enum logic [3:0] {
        IDLE   = IDLE_CODE,
        LAUNCH = LAUNCH_CODE,
        WAIT   = WAIT_CODE,
        DONE   = DONE_CODE
    } state_e;

    localparam logic [STATUS_W-1:0] ST_OK       = 2'b00;
    localparam logic [STATUS_W-1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [STATUS_W-1:0] ST_OK_RETRY = 2'b10;

endpackage : task_launcher_pkg

// File: rtl/launch_timer.sv
// ----------------------------------------------------------------------------
// launch_timer
// Per-attempt timeout counter for the task launcher.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronously clears the count (has priority over en)
//   en       : counts one elapsed WAIT cycle
//   expired  : high while the current cycle is the TIMEOUT-th counted cycle,
//              i.e. the attempt times out at the end of this cycle
// Parameter TIMEOUT (>= 2): cycles per attempt.
// ----------------------------------------------------------------------------
module launch_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count equals the number of WAIT cycles already completed, so the
    // cycle in which it reads TIMEOUT-1 is the last one of the attempt.
    assign expired = (cnt_q == LAST);

    // Next count: clear, advance while enabled, hold once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : launch_timer

// File: rtl/task_launcher.sv
// ----------------------------------------------------------------------------
// task_launcher
// Initiator side of the start/done worker handshake. Accepts a command over
// valid/ready, pulses work_begin for one cycle with the command argument,
// waits for work_end or a timeout and returns a status/cycle-count response.
//   cmd_valid/cmd_ready/cmd_arg : command channel (ready is a decode of IDLE)
//   work_begin/work_arg         : one-cycle start pulse and held argument
//   work_end                    : one-cycle completion pulse, honoured in WAIT
//   rsp_valid/rsp_ready         : response channel
//   rsp_status                  : 00 OK, 01 TIMEOUT, 10 OK_AFTER_RETRY
//   rsp_cycles                  : saturating count of WAIT cycles over attempts
//   busy                        : launcher is not IDLE
// Optional feature: define TASK_LAUNCHER_RETRY_EN to relaunch the same job up
// to MAX_RETRY extra times after a timeout.
// ----------------------------------------------------------------------------
module task_launcher
    import task_launcher_pkg::*;
#(
    parameter int ARG_W     = 8,
    parameter int TIMEOUT   = 1000,
    parameter int CNT_W     = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ARG_W-1:0]    cmd_arg,
    output logic                work_begin,
    output logic [ARG_W-1:0]    work_arg,
    input  logic                work_end,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [STATUS_W-1:0] rsp_status,
    output logic [CNT_W-1:0]    rsp_cycles,
    output logic                busy
);

    // Parameter sanity: an attempt needs at least two WAIT cycles.
    if (TIMEOUT < 2 || MAX_RETRY < 0) begin : g_param_check
        $error("task_launcher: TIMEOUT must be >= 2 and MAX_RETRY >= 0");
    end

    state_e                state_q, state_d;
    logic                  work_begin_q, work_begin_d;
    logic [ARG_W-1:0]      work_arg_q, work_arg_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [STATUS_W-1:0]   rsp_status_q, rsp_status_d;
    logic [CNT_W-1:0]      rsp_cycles_q, rsp_cycles_d;

`ifdef TASK_LAUNCHER_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    logic [RETRY_W-1:0]    retry_q, retry_d;
`endif

    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    // The timer only runs in WAIT; every other state (including a relaunch)
    // starts the next attempt from zero.
    assign timer_en  = (state_q == WAIT);
    assign timer_clr = (state_q != WAIT);

    launch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign work_begin = work_begin_q;
    assign work_arg   = work_arg_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_cycles = rsp_cycles_q;

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that they are registered alongside the state.
    always_comb begin
        state_d      = state_q;
        work_begin_d = 1'b0;
        work_arg_d   = work_arg_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_status_d = rsp_status_q;
        rsp_cycles_d = rsp_cycles_q;
`ifdef TASK_LAUNCHER_RETRY_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            IDLE: begin
                rsp_valid_d = 1'b0;
                if (cmd_valid) begin
                    state_d      = LAUNCH;
                    work_begin_d = 1'b1;
                    work_arg_d   = cmd_arg;
                    rsp_cycles_d = {CNT_W{1'b0}};
`ifdef TASK_LAUNCHER_RETRY_EN
                    retry_d      = {RETRY_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // The current WAIT cycle is counted whatever its outcome.
                if (&rsp_cycles_q) begin
                    rsp_cycles_d = rsp_cycles_q;
                end else begin
                    rsp_cycles_d = rsp_cycles_q + CNT_W'(1);
                end
                // Completion takes precedence over a timeout in the same cycle.
                if (work_end) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
`ifdef TASK_LAUNCHER_RETRY_EN
                    if (retry_q != {RETRY_W{1'b0}}) begin
                        rsp_status_d = ST_OK_RETRY;
                    end else begin
                        rsp_status_d = ST_OK;
                    end
`else
                    rsp_status_d = ST_OK;
`endif
                end else if (timer_expired) begin
`ifdef TASK_LAUNCHER_RETRY_EN
                    if (retry_q < RETRY_LIMIT) begin
                        state_d      = LAUNCH;
                        work_begin_d = 1'b1;
                        retry_d      = retry_q + RETRY_W'(1);
                    end else begin
                        state_d      = DONE;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_TIMEOUT;
                    end
`else
                    state_d      = DONE;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
`endif
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                // Illegal encoding: recover to IDLE without issuing anything.
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            work_begin_q <= 1'b0;
            work_arg_q   <= {ARG_W{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= ST_OK;
            rsp_cycles_q <= {CNT_W{1'b0}};
`ifdef TASK_LAUNCHER_RETRY_EN
            retry_q      <= {RETRY_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            work_begin_q <= work_begin_d;
            work_arg_q   <= work_arg_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_cycles_q <= rsp_cycles_d;
`ifdef TASK_LAUNCHER_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

endmodule : task_launcher
